ro_window_counter: RTL and testbench
====================================

// Module: ro_window_counter
// PURPOSE
// - Measurement front end of the RO-PUF datapath.
// - Opens a fixed-length measurement window on a start pulse and counts rising edges of one
//   asynchronous ring-oscillator input inside that window.
// - Exposes the window timebase (win_cnt) and its terminal flag (cnt_max).
// - Returns the frozen edge count with a one-cycle done pulse; the downstream comparator and
//   response-bit logic consume the result.
// PARAMETERS
// - WINDOW_CYCLES  60000000  measurement window length in clk cycles (>=2)
// - CNT_W          32        width of ro_count and win_cnt
// - SYNC_STAGES    2         synchroniser flops on ro_in (>=2)
// PORTS
// - clk       in   1      system clock, all logic on posedge
// - rst       in   1      asynchronous, active-high reset
// - start     in   1      request a measurement; sampled only in IDLE
// - ro_in     in   1      ring-oscillator output, asynchronous to clk
// - busy      out  1      high in ARM, MEASURE and DONE
// - done      out  1      one-cycle pulse: ro_count valid
// - ro_count  out  CNT_W  RO rising edges counted in the last window
// - win_cnt   out  CNT_W  window cycle index, 0..WINDOW_CYCLES-1
// - cnt_max   out  1      high on the last window cycle (MEASURE, win_cnt==WINDOW_CYCLES-1)
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; busy=0, done=0, ro_count=0, win_cnt=0, cnt_max=0.
//   Synchroniser and edge-detect flops cleared. Reset mid-window discards the partial count.
// - Edge detect: ro_in -> SYNC_STAGES flops -> delay flop.
//   ro_edge = sync_out & ~sync_dly (one clk pulse per rising edge).
// - FSM states: IDLE, ARM, MEASURE, DONE (all outputs registered except cnt_max).
//   - IDLE: start=1 -> ARM; ro_count cleared to 0, win_cnt=0.
//   - ARM: lasts SYNC_STAGES+1 cycles, flushing the synchroniser; edges ignored.
//     ARM -> MEASURE.
//   - MEASURE: exactly WINDOW_CYCLES cycles; win_cnt increments from 0 each cycle.
//     ro_edge increments ro_count in every MEASURE cycle, including the last.
//     At win_cnt==WINDOW_CYCLES-1 -> DONE.
//   - DONE: one cycle; done=1, busy=1; ro_count frozen. Next state IDLE.
// - ro_count holds its value in IDLE until the next accepted start.
// - start outside IDLE is ignored. No queuing.
// - start held high: a new measurement begins on the first IDLE cycle after DONE.
// - Latency: start (IDLE) -> done = SYNC_STAGES+1 + WINDOW_CYCLES + 1 cycles.
// - win_cnt: holds WINDOW_CYCLES-1 in DONE; returns to 0 in IDLE.
// - ro_count overflow (2^CNT_W-1 reached): see CONFIGURATION.
// CONFIGURATION
// - Macro RO_SAT_FLAG_EN.
//   - Defined:
//     - ro_count saturates at 2^CNT_W-1.
//     - Adds output ro_sat (1 bit): reset 0; cleared on an accepted start; set and held when an
//       edge arrives at saturation; valid alongside done.
//   - Undefined:
//     - No ro_sat port.
//     - ro_count wraps modulo 2^CNT_W.
// TESTING
// 1. Assert rst during MEASURE -> same cycle: busy=0, ro_count=0, win_cnt=0; done never pulses.
// 2. WINDOW_CYCLES=16, ro_in toggles every clk (period 2 clk), start pulse
//    -> done 20 cycles after start; ro_count=8; cnt_max high exactly 1 cycle, with win_cnt=15.
// 3. WINDOW_CYCLES=16, ro_in held 1 before and through start -> ro_count=0 (ARM flush, no edge).
// 4. start held high continuously -> back-to-back windows; each done followed by one IDLE cycle;
//    ro_count=8 each time.
// 5. start pulsed during MEASURE -> ignored: single done; ro_count unchanged vs test 2.
// 6. CNT_W=4, WINDOW_CYCLES=40, ro toggling every clk (20 edges):
//    - RO_SAT_FLAG_EN defined   -> ro_count=15, ro_sat=1.
//    - RO_SAT_FLAG_EN undefined -> ro_count=4.

Source files
------------

// File: rtl/ro_window_counter.sv
// Ring-oscillator window counter: counts synchronised RO rising edges over a fixed clk window.
// Optional macro RO_SAT_FLAG_EN: saturating ro_count plus a sticky ro_sat flag; otherwise ro_count wraps.
module ro_window_counter #(
  parameter int WINDOW_CYCLES = 60000000,
  parameter int CNT_W         = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ro_count,
  output logic [CNT_W-1:0] win_cnt,
`ifdef RO_SAT_FLAG_EN
  output logic             ro_sat,
`endif
  output logic             cnt_max
);

  // The window timebase is kept wide enough for WINDOW_CYCLES even when CNT_W is narrower.
  localparam int WIN_LOG = $clog2(WINDOW_CYCLES);
  localparam int WIN_W   = (CNT_W > WIN_LOG) ? CNT_W : WIN_LOG;
  localparam int ARM_W   = $clog2(SYNC_STAGES + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ARM_W-1:0]     arm_q, arm_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 sync_dly_q;
  logic                 ro_edge;
`ifdef RO_SAT_FLAG_EN
  logic                 sat_q, sat_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ro_in};
      sync_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ro_edge = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
`ifdef RO_SAT_FLAG_EN
    sat_d   = sat_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        win_d = '0;
        if (start) begin
          state_d = ST_ARM;
          arm_d   = '0;
          cnt_d   = '0;
`ifdef RO_SAT_FLAG_EN
          sat_d   = 1'b0;
`endif
        end
      end
      // ARM lets the synchroniser settle so a level already high is never seen as an edge.
      ST_ARM: begin
        if (arm_q == ARM_LAST) begin
          state_d = ST_MEASURE;
        end else begin
          arm_d = arm_q + ARM_W'(1);
        end
      end
      ST_MEASURE: begin
        if (ro_edge) begin
`ifdef RO_SAT_FLAG_EN
          if (cnt_q == '1) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
        if (win_q == WIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        win_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      arm_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RO_SAT_FLAG_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef RO_SAT_FLAG_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ro_count = cnt_q;
  assign win_cnt  = win_q[CNT_W-1:0];
  assign cnt_max  = (state_q == ST_MEASURE) && (win_q == WIN_LAST);
`ifdef RO_SAT_FLAG_EN
  assign ro_sat   = sat_q;
`endif

endmodule

// File: tb/tb_ro_window_counter.sv
// Bench for ro_window_counter: a 16-cycle window instance and a narrow 4-bit, 40-cycle instance
// sharing one RO stimulus; expected counts come from the recorded ro_in history.
`timescale 1ns/1ps
module tb_ro_window_counter;
  localparam int S    = 2;
  localparam int W_A  = 16;
  localparam int W_B  = 40;
  localparam int HMAX = 16384;

  logic        clk = 1'b0, rst = 1'b1, ro_in = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        busy_a, done_a, cnt_max_a;
  logic [31:0] ro_count_a, win_cnt_a;
  logic        busy_b, done_b, cnt_max_b;
  logic [3:0]  ro_count_b, win_cnt_b;
`ifdef RO_SAT_FLAG_EN
  logic        ro_sat_a, ro_sat_b;
`endif

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int mode = 0;
  bit hist [0:HMAX-1];

  ro_window_counter #(.WINDOW_CYCLES(W_A), .CNT_W(32), .SYNC_STAGES(S)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ro_in(ro_in),
    .busy(busy_a), .done(done_a), .ro_count(ro_count_a), .win_cnt(win_cnt_a),
`ifdef RO_SAT_FLAG_EN
    .ro_sat(ro_sat_a),
`endif
    .cnt_max(cnt_max_a)
  );

  ro_window_counter #(.WINDOW_CYCLES(W_B), .CNT_W(4), .SYNC_STAGES(S)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ro_in(ro_in),
    .busy(busy_b), .done(done_b), .ro_count(ro_count_b), .win_cnt(win_cnt_b),
`ifdef RO_SAT_FLAG_EN
    .ro_sat(ro_sat_b),
`endif
    .cnt_max(cnt_max_b)
  );

  always #5 clk = ~clk;

  // RO stimulus: changes 1ns after each posedge; hist[n] is the level held during cycle n.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (mode)
        1:       ro_in = ~ro_in;
        2:       ro_in = 1'($urandom_range(0, 1));
        3:       ro_in = 1'b1;
        default: ro_in = 1'b0;
      endcase
      if (cyc < HMAX) hist[cyc] = ro_in;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Rising transitions of ro_in into cycles first_arm+1 .. first_arm+w form the measured window.
  function automatic int model_edges(input int first_arm, input int w);
    int n = 0;
    for (int j = 1; j <= w; j++)
      if (hist[first_arm + j] && !hist[first_arm + j - 1]) n++;
    return n;
  endfunction

  task automatic pulse_a(output int first_arm);
    @(negedge clk);
    start_a = 1'b1;
    first_arm = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // Observes dut_a from the current negedge until done or budget expiry.
  task automatic watch_a(input int budget, output int dcyc, output int nmax, output int wmax,
                         output int idle_seen);
    dcyc = -1; nmax = 0; wmax = -1; idle_seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (cnt_max_a) begin nmax++; wmax = int'(win_cnt_a); end
      if (!busy_a) idle_seen++;
      if (done_a) begin dcyc = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    n_chk++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_a); end
    n_chk++; if (ro_count_a !== 32'd0) begin n_fail++; $display("FAIL reset_ro_count: got %0d expected 0", ro_count_a); end
    n_chk++; if (win_cnt_a !== 32'd0) begin n_fail++; $display("FAIL reset_win_cnt: got %0d expected 0", win_cnt_a); end
    n_chk++; if (cnt_max_a !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_max: got %b expected 0", cnt_max_a); end
    n_chk++; if (ro_count_b !== 4'd0 || win_cnt_b !== 4'd0) begin n_fail++; $display("FAIL reset_b_counts: got %0d/%0d expected 0/0", ro_count_b, win_cnt_b); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy_a); end
  endtask

  task automatic test_window();
    int fa, dcyc, nmax, wmax, idl;
    mode = 1;
    repeat (3) @(negedge clk);
    pulse_a(fa);
    watch_a(60, dcyc, nmax, wmax, idl);
    n_chk++; if (dcyc !== fa - 1 + 20) begin n_fail++; $display("FAIL window_done_cycle: got %0d expected %0d", dcyc, fa - 1 + 20); end
    n_chk++; if (nmax !== 1) begin n_fail++; $display("FAIL window_cnt_max_cycles: got %0d expected 1", nmax); end
    n_chk++; if (wmax !== W_A - 1) begin n_fail++; $display("FAIL window_win_at_max: got %0d expected %0d", wmax, W_A - 1); end
    n_chk++; if (idl !== 0) begin n_fail++; $display("FAIL window_busy_gap: got %0d idle cycles expected 0", idl); end
    n_chk++; if (ro_count_a !== 32'd8) begin n_fail++; $display("FAIL window_ro_count: got %0d expected 8", ro_count_a); end
    n_chk++; if (ro_count_a !== 32'(model_edges(fa, W_A))) begin n_fail++; $display("FAIL window_model: got %0d expected %0d", ro_count_a, model_edges(fa, W_A)); end
    n_chk++; if (win_cnt_a !== 32'(W_A - 1)) begin n_fail++; $display("FAIL done_win_cnt: got %0d expected %0d", win_cnt_a, W_A - 1); end
`ifdef RO_SAT_FLAG_EN
    n_chk++; if (ro_sat_a !== 1'b0) begin n_fail++; $display("FAIL window_ro_sat: got %b expected 0", ro_sat_a); end
`endif
    @(negedge clk);
    n_chk++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL after_done_flags: got busy=%b done=%b expected 0/0", busy_a, done_a); end
    n_chk++; if (win_cnt_a !== 32'd0) begin n_fail++; $display("FAIL idle_win_cnt: got %0d expected 0", win_cnt_a); end
    repeat (4) @(negedge clk);
    n_chk++; if (ro_count_a !== 32'd8) begin n_fail++; $display("FAIL idle_hold_count: got %0d expected 8", ro_count_a); end
  endtask

  task automatic test_arm_flush();
    int fa, dcyc, nmax, wmax, idl;
    mode = 3;
    repeat (6) @(negedge clk);
    pulse_a(fa);
    watch_a(60, dcyc, nmax, wmax, idl);
    n_chk++; if (dcyc !== fa + S + 1 + W_A) begin n_fail++; $display("FAIL flush_done_cycle: got %0d expected %0d", dcyc, fa + S + 1 + W_A); end
    n_chk++; if (ro_count_a !== 32'd0) begin n_fail++; $display("FAIL flush_ro_count: got %0d expected 0", ro_count_a); end
    mode = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int fa, dcyc, nmax, wmax, idl;
    mode = 1;
    @(negedge clk);
    start_a = 1'b1;
    fa = cyc + 1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      watch_a(60, dcyc, nmax, wmax, idl);
      n_chk++; if (dcyc !== fa + S + 1 + W_A) begin n_fail++; $display("FAIL b2b_done_cycle[%0d]: got %0d expected %0d", k, dcyc, fa + S + 1 + W_A); end
      n_chk++; if (ro_count_a !== 32'(model_edges(fa, W_A)) || ro_count_a !== 32'd8) begin n_fail++; $display("FAIL b2b_ro_count[%0d]: got %0d expected 8", k, ro_count_a); end
      @(negedge clk);
      n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap[%0d]: got busy=%b expected 0", k, busy_a); end
      if (k == 2) start_a = 1'b0;
      fa = cyc + 1;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: got busy=%b expected 0", busy_a); end
  endtask

  task automatic test_start_ignored();
    int fa, ndone, dcyc;
    mode = 1;
    pulse_a(fa);
    repeat (5) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    ndone = 0; dcyc = -1;
    for (int i = 0; i < 60; i++) begin
      if (done_a) begin ndone++; if (dcyc < 0) dcyc = cyc; end
      @(negedge clk);
    end
    n_chk++; if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
    n_chk++; if (dcyc !== fa + S + 1 + W_A) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d expected %0d", dcyc, fa + S + 1 + W_A); end
    n_chk++; if (ro_count_a !== 32'd8) begin n_fail++; $display("FAIL ignore_ro_count: got %0d expected 8", ro_count_a); end
  endtask

  task automatic test_reset_mid();
    int fa, ndone;
    mode = 1;
    pulse_a(fa);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy_a); end
    n_chk++; if (ro_count_a !== 32'd0) begin n_fail++; $display("FAIL midrst_ro_count: got %0d expected 0", ro_count_a); end
    n_chk++; if (win_cnt_a !== 32'd0) begin n_fail++; $display("FAIL midrst_win_cnt: got %0d expected 0", win_cnt_a); end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < W_A + 10; i++) begin
      if (done_a || busy_a) ndone++;
      @(negedge clk);
    end
    n_chk++; if (ndone !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", ndone); end
  endtask

  task automatic test_random();
    int fa, dcyc, nmax, wmax, idl, exp;
    mode = 2;
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      pulse_a(fa);
      watch_a(60, dcyc, nmax, wmax, idl);
      exp = model_edges(fa, W_A);
      n_chk++; if (dcyc !== fa + S + 1 + W_A) begin n_fail++; $display("FAIL rand_done_cycle[%0d]: got %0d expected %0d", r, dcyc, fa + S + 1 + W_A); end
      n_chk++; if (ro_count_a !== 32'(exp)) begin n_fail++; $display("FAIL rand_ro_count[%0d]: got %0d expected %0d", r, ro_count_a, exp); end
      n_chk++; if (nmax !== 1) begin n_fail++; $display("FAIL rand_cnt_max[%0d]: got %0d expected 1", r, nmax); end
    end
    mode = 0;
  endtask

  task automatic test_overflow();
    int fb, dcyc, nmax, m, exp;
    mode = 1;
    @(negedge clk);
    start_b = 1'b1;
    fb = cyc + 1;
    @(negedge clk);
    start_b = 1'b0;
    dcyc = -1; nmax = 0;
    for (int i = 0; i < 100; i++) begin
      if (cnt_max_b) nmax++;
      if (done_b) begin dcyc = cyc; break; end
      @(negedge clk);
    end
    m = model_edges(fb, W_B);
`ifdef RO_SAT_FLAG_EN
    exp = (m > 15) ? 15 : m;
`else
    exp = m % 16;
`endif
    n_chk++; if (dcyc !== fb + S + 1 + W_B) begin n_fail++; $display("FAIL ovf_done_cycle: got %0d expected %0d", dcyc, fb + S + 1 + W_B); end
    n_chk++; if (nmax !== 1) begin n_fail++; $display("FAIL ovf_cnt_max: got %0d expected 1", nmax); end
    n_chk++; if (ro_count_b !== 4'(exp)) begin n_fail++; $display("FAIL ovf_ro_count: got %0d expected %0d", ro_count_b, exp); end
`ifdef RO_SAT_FLAG_EN
    n_chk++; if (ro_sat_b !== (m > 15)) begin n_fail++; $display("FAIL ovf_ro_sat: got %b expected %b", ro_sat_b, (m > 15)); end
`endif
    @(negedge clk);
    n_chk++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL ovf_idle: got busy=%b expected 0", busy_b); end
    mode = 0;
  endtask

  initial begin
    test_reset();
    test_window();
    test_arm_flush();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
